rsa_expmod_ctrl: RTL and testbench

Sequencer for the RSA peripheral's modular-exponentiation datapath.
- Runs left-to-right square-and-multiply over a WIDTH-bit exponent.
- Issues one operation at a time to the shared Montgomery multiplier via a start/done handshake.
- Drives the operation code and the select of the 2:1 operand mux that chooses between accumulator and Montgomery-domain base.
- Always processes all WIDTH exponent bits, so the operation count depends only on the exponent's popcount, not its leading zeros.

---
 rtl/rsa_expmod_ctrl_pkg.sv | 43 ++++
 rtl/rsa_expmod_ctrl_if.sv | 35 +++
 rtl/rsa_expmod_ctrl.sv | 149 ++++++++++++++
 tb/tb_rsa_expmod_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_expmod_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rsa_ctrl_pkg
// Shared types for the RSA modular-exponentiation sequencer:
//   rsa_op_t    - operation code presented to the Montgomery datapath
//   rsa_state_t - sequencer FSM states
//   op-count helpers for sizing test budgets and future CRT controllers
// -----------------------------------------------------------------------------
package rsa_ctrl_pkg;

    // Operation codes; the datapath routes the multiplier result by op.
    typedef enum logic [2:0] {
        CONV = 3'd0,   // base_m = mont(base, R2)
        INIT = 3'd1,   // acc    = mont(1, R2)
        SQR  = 3'd2,   // acc    = mont(acc, acc)
        MUL  = 3'd3,   // acc    = mont(acc, base_m)
        POST = 3'd4    // acc    = mont(acc, 1)
    } rsa_op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } rsa_state_t;

    // CONV, INIT and POST bracket the per-bit square/multiply work.
    localparam int unsigned FIXED_OPS       = 32'd3;
    // At most one SQR and one MUL per exponent bit.
    localparam int unsigned MAX_OPS_PER_BIT = 32'd2;

    // Number of multiplier operations for an exponent with 'ones' set bits.
    function automatic int unsigned op_count(input int unsigned width,
                                             input int unsigned ones);
        return width + ones + FIXED_OPS;
    endfunction

    // Worst-case operation count (all-ones exponent).
    function automatic int unsigned max_op_count(input int unsigned width);
        return MAX_OPS_PER_BIT * width + FIXED_OPS;
    endfunction

endpackage

// File: rtl/rsa_expmod_ctrl_if.sv
// -----------------------------------------------------------------------------
// rsa_expmod_ctrl_if
// Bundles the host request/status signals and the Montgomery multiplier
// handshake of the exponentiation sequencer.
//   start, exponent      host request (exponent sampled on accepted start)
//   busy, done           sequencer status
//   mmm_start, mmm_done  multiplier launch / completion pulses
//   op, b_sel, acc_we    datapath control (op code, operand mux, write strobe)
// Modports:
//   slave  - the sequencer itself
//   master - the environment (host + multiplier + datapath)
// -----------------------------------------------------------------------------
interface rsa_expmod_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] exponent;
    logic             busy;
    logic             done;
    logic             mmm_start;
    logic             mmm_done;
    logic [2:0]       op;
    logic             b_sel;
    logic             acc_we;

    modport slave (
        input  start, exponent, mmm_done,
        output busy, done, mmm_start, op, b_sel, acc_we
    );

    modport master (
        output start, exponent, mmm_done,
        input  busy, done, mmm_start, op, b_sel, acc_we
    );
endinterface

// File: rtl/rsa_expmod_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_expmod_ctrl
// Left-to-right square-and-multiply sequencer for the RSA modexp datapath.
// Issues one Montgomery operation at a time (CONV, INIT, {SQR, [MUL]} per
// exponent bit, POST) and always walks all WIDTH bits, so the op count
// depends only on the exponent's popcount.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rsa_expmod_ctrl_if.slave (start/exponent in, busy/done out,
//          mmm_start/mmm_done handshake, op/b_sel/acc_we datapath control)
// All outputs are registered except acc_we, which is a zero-latency decode
// of mmm_done while waiting so the datapath captures the result on time.
// -----------------------------------------------------------------------------
module rsa_expmod_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    rsa_expmod_ctrl_if.slave  bus
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rsa_state_t       state_r;
    rsa_op_t          op_r;
    logic [CW-1:0]    cnt_r;       // index of the exponent bit being processed
    logic [WIDTH-1:0] e_r;         // exponent, MSB is the current bit
    logic             busy_r;
    logic             done_r;
    logic             mmm_start_r;
    logic             b_sel_r;

    rsa_op_t          next_op_s;
    logic             advance_s;   // move to the next exponent bit

    // Next-operation decision applied when the current op completes.
    always_comb begin
        next_op_s = POST;
        advance_s = 1'b0;
        case (op_r)
            CONV: begin
                next_op_s = INIT;
            end
            INIT: begin
                next_op_s = SQR;
            end
            SQR: begin
                if (e_r[WIDTH-1]) begin
                    next_op_s = MUL;
                end else if (cnt_r == CNT_ZERO) begin
                    next_op_s = POST;
                end else begin
                    next_op_s = SQR;
                    advance_s = 1'b1;
                end
            end
            MUL: begin
                if (cnt_r == CNT_ZERO) begin
                    next_op_s = POST;
                end else begin
                    next_op_s = SQR;
                    advance_s = 1'b1;
                end
            end
            default: begin
                next_op_s = POST;
                advance_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_r        <= CONV;
            cnt_r       <= CNT_INIT;
            e_r         <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mmm_start_r <= 1'b0;
            b_sel_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        e_r         <= bus.exponent;
                        cnt_r       <= CNT_INIT;
                        op_r        <= CONV;
                        b_sel_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        mmm_start_r <= 1'b1;
                        state_r     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mmm_start_r <= 1'b0;
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mmm_done) begin
                        if (op_r == POST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_FIN;
                        end else begin
                            op_r        <= next_op_s;
                            b_sel_r     <= (next_op_s == MUL);
                            mmm_start_r <= 1'b1;
                            state_r     <= S_ISSUE;
                            if (advance_s) begin
                                cnt_r <= cnt_r - CNT_ONE;
                                e_r   <= {e_r[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_FIN: begin
                    // start seen here is deliberately dropped; the host must
                    // still be asserting it in the following IDLE cycle.
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    mmm_start_r <= 1'b0;
                    b_sel_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.mmm_start = mmm_start_r;
    assign bus.op        = op_r;
    assign bus.b_sel     = b_sel_r;
    assign bus.acc_we    = (state_r == S_WAIT) && bus.mmm_done;

endmodule

// File: tb/tb_rsa_expmod_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rsa_expmod_ctrl
// Self-checking bench for rsa_expmod_ctrl (WIDTH=4). A behavioural multiplier
// answers each mmm_start after k cycles; a monitor logs every issued op and
// status pulse relative to the start cycle; expected sequences and timings
// come from the square-and-multiply definition.
// -----------------------------------------------------------------------------
module tb_rsa_expmod_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    rsa_expmod_ctrl_if #(.WIDTH(W)) bus ();

    rsa_expmod_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;
    int cyc = 0;
    int base = 0;

    // multiplier model
    int k_lat = 1;
    int cd = 0;
    int force_cyc = -1;
    bit hit;

    // monitor logs
    bit logging = 1'b0;
    int rel_m;
    int ops_q[$];
    int scyc_q[$];
    int exp_q[$];
    int bsel_cnt, bsel_start_cnt, bsel_bad, we_cnt;
    int busy_cnt, busy_first, busy_last, done_cnt, done_cyc;

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiplier: mmm_done k cycles after mmm_start, plus optional forced pulse.
    initial begin
        bus.mmm_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hit = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) hit = 1'b1;
            end
            bus.mmm_done = hit || (cyc == force_cyc);
        end
    end

    // Monitor, sampling mid-cycle.
    initial forever begin
        @(negedge clk);
        if (bus.mmm_start === 1'b1) cd = k_lat;
        if (logging) begin
            rel_m = cyc - base;
            if (bus.mmm_start === 1'b1) begin
                ops_q.push_back(int'(bus.op));
                scyc_q.push_back(rel_m);
                if (bus.b_sel === 1'b1) bsel_start_cnt++;
            end
            if (bus.b_sel === 1'b1) bsel_cnt++;
            if (bus.b_sel !== (bus.op == 3'd3)) bsel_bad++;
            if (bus.acc_we === 1'b1) we_cnt++;
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = rel_m;
                busy_last = rel_m;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = rel_m;
            end
        end
    end

    function automatic void clear_logs();
        ops_q.delete();
        scyc_q.delete();
        bsel_cnt = 0; bsel_start_cnt = 0; bsel_bad = 0; we_cnt = 0;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        done_cnt = 0; done_cyc = -1;
    endfunction

    // Reference op list: CONV, INIT, per bit MSB..LSB {SQR, MUL if set}, POST.
    function automatic void build_model(input logic [W-1:0] e);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(1);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back(2);
            if (e[i]) exp_q.push_back(3);
        end
        exp_q.push_back(4);
    endfunction

    function automatic int seq_diffs();
        int n = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (j >= ops_q.size() || ops_q[j] != exp_q[j]) n++;
        if (ops_q.size() != exp_q.size()) n++;
        return n;
    endfunction

    task automatic launch(input logic [W-1:0] e, input int k, input bit hold);
        k_lat = k;
        clear_logs();
        build_model(e);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.exponent = e;
        base = cyc;
        logging = 1'b1;
        if (!hold) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) ok = 1'b1;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.exponent = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({bus.busy, bus.done, bus.mmm_start, bus.acc_we, bus.b_sel} !== 5'b0) begin
            err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.busy, bus.done, bus.mmm_start, bus.acc_we, bus.b_sel});
        end
        vec++;
        if (bus.op !== 3'd0) begin
            err++;
            $display("FAIL reset_op: got %0d want 0", bus.op);
        end
    endtask

    task automatic test_exp_1011();
        bit ok;
        int n;
        launch(4'b1011, 3, 1'b0);
        wait_done(200, ok);
        vec++;
        if (!ok) begin err++; $display("FAIL e1011_timeout: done not seen within 200 cycles"); end
        vec++;
        n = seq_diffs();
        if (n != 0) begin
            err++;
            $display("FAIL e1011_seq: got %0d ops (%0d diffs) want %0d ops", ops_q.size(), n, exp_q.size());
        end
        n = 0;
        for (int j = 0; j < scyc_q.size(); j++) if (scyc_q[j] != 1 + 4 * j) n++;
        vec++;
        if (n != 0 || scyc_q.size() != 10 || scyc_q[9] != 37) begin
            err++;
            $display("FAIL e1011_start_cycles: got %0d starts, %0d off-time, want 10 at 1,5..37", scyc_q.size(), n);
        end
        vec++;
        if (done_cyc != 41 || done_cnt != 1) begin
            err++;
            $display("FAIL e1011_done: got cycle %0d count %0d want cycle 41 count 1", done_cyc, done_cnt);
        end
        vec++;
        if (busy_first != 1 || busy_last != 40 || busy_cnt != 40) begin
            err++;
            $display("FAIL e1011_busy: got %0d..%0d (%0d) want 1..40 (40)", busy_first, busy_last, busy_cnt);
        end
        vec++;
        if (bsel_start_cnt != 3 || bsel_cnt != 12 || bsel_bad != 0) begin
            err++;
            $display("FAIL e1011_bsel: got %0d MUL starts, %0d cycles, %0d bad want 3,12,0",
                     bsel_start_cnt, bsel_cnt, bsel_bad);
        end
        vec++;
        if (we_cnt != 10) begin err++; $display("FAIL e1011_acc_we: got %0d want 10", we_cnt); end
        logging = 1'b0;
    endtask

    task automatic test_exp_zero();
        bit ok;
        int n;
        launch(4'b0000, 1, 1'b0);
        wait_done(100, ok);
        n = seq_diffs();
        vec++;
        if (!ok || n != 0) begin
            err++;
            $display("FAIL e0_seq: got %0d ops (%0d diffs, done=%0d) want 7 ops", ops_q.size(), n, ok);
        end
        vec++;
        if (done_cyc != 15) begin err++; $display("FAIL e0_done: got cycle %0d want 15", done_cyc); end
        vec++;
        if (bsel_cnt != 0) begin err++; $display("FAIL e0_bsel: got %0d b_sel cycles want 0", bsel_cnt); end
        logging = 1'b0;
    endtask

    task automatic test_exp_ones();
        bit ok;
        int n;
        launch(4'b1111, 2, 1'b0);
        wait_done(100, ok);
        n = seq_diffs();
        vec++;
        if (!ok || n != 0 || ops_q.size() != 11) begin
            err++;
            $display("FAIL e1111_seq: got %0d ops (%0d diffs) want 11", ops_q.size(), n);
        end
        vec++;
        if (we_cnt != 11) begin err++; $display("FAIL e1111_acc_we: got %0d want 11", we_cnt); end
        logging = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int n, k, nops, bad_t;
        logic [W-1:0] e;
        for (int r = 0; r < 12; r++) begin
            e = W'($urandom_range(0, (1 << W) - 1));
            k = $urandom_range(1, 4);
            launch(e, k, 1'b0);
            wait_done(300, ok);
            nops = exp_q.size();
            n = seq_diffs();
            bad_t = 0;
            for (int j = 0; j < scyc_q.size(); j++) if (scyc_q[j] != 1 + j * (k + 1)) bad_t++;
            vec++;
            if (!ok || n != 0 || bad_t != 0) begin
                err++;
                $display("FAIL rand_seq: e=%b k=%0d got %0d ops (%0d diffs, %0d mistimed) want %0d",
                         e, k, ops_q.size(), n, bad_t, nops);
            end
            vec++;
            if (done_cyc != 1 + (nops - 1) * (k + 1) + k + 1 || we_cnt != nops || bsel_bad != 0) begin
                err++;
                $display("FAIL rand_timing: e=%b k=%0d got done %0d we %0d bsel_bad %0d want done %0d we %0d",
                         e, k, done_cyc, we_cnt, bsel_bad, 1 + (nops - 1) * (k + 1) + k + 1, nops);
            end
            logging = 1'b0;
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        int n;
        logic [W-1:0] e;
        e = W'($urandom_range(0, (1 << W) - 1));
        launch(e, 2, 1'b0);
        force_cyc = base + 7;          // ISSUE cycle of the third op
        repeat (8) @(posedge clk);
        #1;
        bus.exponent = ~e;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(200, ok);
        force_cyc = -1;
        n = seq_diffs();
        vec++;
        if (!ok || n != 0) begin
            err++;
            $display("FAIL ignore_seq: e=%b got %0d ops (%0d diffs) want %0d", e, ops_q.size(), n, exp_q.size());
        end
        vec++;
        if (we_cnt != exp_q.size() || done_cyc != 1 + (exp_q.size() - 1) * 3 + 3) begin
            err++;
            $display("FAIL ignore_we: got we %0d done %0d want we %0d done %0d",
                     we_cnt, done_cyc, exp_q.size(), 1 + (exp_q.size() - 1) * 3 + 3);
        end
        logging = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int n, we_snap;
        logic [W-1:0] e;
        e = W'($urandom_range(0, (1 << W) - 1));
        launch(e, 3, 1'b0);
        repeat (13) @(posedge clk);    // cycle 14: WAIT of the 4th op
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({bus.busy, bus.done, bus.mmm_start, bus.acc_we, bus.b_sel, bus.op} !== 8'b0) begin
            err++;
            $display("FAIL midrst_outputs: got %b want 00000000",
                     {bus.busy, bus.done, bus.mmm_start, bus.acc_we, bus.b_sel, bus.op});
        end
        #1;
        we_snap = we_cnt;
        repeat (6) @(negedge clk);     // orphaned mmm_done lands in cycle 16
        #1;
        vec++;
        if (we_cnt != we_snap || ops_q.size() != 4) begin
            err++;
            $display("FAIL midrst_discard: got %0d extra acc_we, %0d ops want 0 extra, 4 ops",
                     we_cnt - we_snap, ops_q.size());
        end
        logging = 1'b0;
        e = W'($urandom_range(0, (1 << W) - 1));
        launch(e, 1, 1'b0);
        wait_done(100, ok);
        n = seq_diffs();
        vec++;
        if (!ok || n != 0 || we_cnt != exp_q.size()) begin
            err++;
            $display("FAIL midrst_rerun: got %0d ops (%0d diffs) we %0d want %0d ops",
                     ops_q.size(), n, we_cnt, exp_q.size());
        end
        logging = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        logic [W-1:0] e;
        e = W'($urandom_range(0, (1 << W) - 1));
        k_lat = 1;
        clear_logs();
        build_model(e);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.exponent = e;
        base = cyc;
        logging = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) ok = 1'b1;
        end
        d = done_cyc;
        @(negedge clk);
        vec++;
        if (!ok || bus.mmm_start !== 1'b0) begin
            err++;
            $display("FAIL b2b_gap: done=%0d mmm_start at done+1 got %b want 0", ok, bus.mmm_start);
        end
        @(negedge clk);
        vec++;
        if (bus.mmm_start !== 1'b1 || bus.op !== 3'd0) begin
            err++;
            $display("FAIL b2b_restart: at done+2 (cycle %0d) got mmm_start %b op %0d want 1, 0",
                     d + 2, bus.mmm_start, bus.op);
        end
        #1;
        bus.start = 1'b0;
        done_cnt = 0;
        wait_done(100, ok);
        vec++;
        if (!ok || ops_q.size() != 2 * exp_q.size()) begin
            err++;
            $display("FAIL b2b_second: got %0d ops total want %0d", ops_q.size(), 2 * exp_q.size());
        end
        logging = 1'b0;
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_exp_1011();
        test_exp_zero();
        test_exp_ones();
        test_random();
        test_ignored_inputs();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
